// File: rtl/wbs_event_irq_ctrl.sv
// Event/interrupt controller on the user-project Wishbone slave bus.
// Each event input gets edge capture into a sticky pending bit, a saturating
// edge counter, an enable mask and routing to any of the irq lines.
module wbs_event_irq_ctrl #(
    parameter int          NUM_EVT   = 8,
    parameter int          NUM_IRQ   = 3,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_dat_i,
    input  logic [31:0]        wbs_adr_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    input  logic [NUM_EVT-1:0] evt_i,
    output logic [NUM_IRQ-1:0] irq,
    output logic               evt_pending_o
);

    // Word indices (byte offset / 4) inside the register block.
    localparam logic [5:0] IDX_STATUS  = 6'd0;
    localparam logic [5:0] IDX_PENDING = 6'd1;
    localparam logic [5:0] IDX_ENABLE  = 6'd2;
    localparam logic [5:0] IDX_MODE    = 6'd3;
    localparam int         IDX_ROUTE   = 8;
    localparam int         IDX_COUNT   = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               req;
    logic               hit;
    logic               wr_en;
    logic [5:0]         idx;
    logic [31:0]        byte_mask;
    logic [NUM_EVT-1:0] wmask;
    logic [NUM_EVT-1:0] wdata;
    logic [NUM_EVT-1:0] evt_prev;
    logic [NUM_EVT-1:0] evt_edge;
    logic [NUM_EVT-1:0] pending;
    logic [NUM_EVT-1:0] enable;
    logic [NUM_EVT-1:0] mode;
    logic [NUM_EVT-1:0] route [NUM_IRQ];
    logic [CNT_W-1:0]   count [NUM_EVT];
    logic [NUM_EVT-1:0] cnt_clr;
    logic [NUM_IRQ-1:0] route_wr;
    logic [31:0]        rdata;

    // Address bits [1:0] and data/mask bits above NUM_EVT carry no information.
    logic unused_bits;
    assign unused_bits = ^{wbs_dat_i, wbs_adr_i[1:0], byte_mask};

    // A request is only taken while no ack is outstanding, so each transfer
    // occupies two cycles and cannot be double-counted.
    assign req       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign idx       = wbs_adr_i[7:2];
    assign wr_en     = req & wbs_we_i & hit;
    assign byte_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                        {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign wmask     = byte_mask[NUM_EVT-1:0];
    assign wdata     = wbs_dat_i[NUM_EVT-1:0];

    // MODE selects falling (1) or rising (0) edge; the registered MODE is used,
    // so a MODE write lands after the edge decision of that same cycle.
    assign evt_edge = (mode & evt_prev & ~evt_i) | (~mode & ~evt_prev & evt_i);

    // Decode per-instance write strobes for the ROUTE and COUNT arrays.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        cnt_clr  = '0;
        route_wr = '0;
        for (int i = 0; i < NUM_EVT; i++)
            cnt_clr[i] = wr_en && (idx == 6'(IDX_COUNT + i)) && (wbs_sel_i != 4'b0000);
        for (int k = 0; k < NUM_IRQ; k++)
            route_wr[k] = wr_en && (idx == 6'(IDX_ROUTE + k));
    end

    // Read data mux; unmapped offsets and foreign addresses read as zero.
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (idx)
                IDX_STATUS:  rdata = 32'(evt_i);
                IDX_PENDING: rdata = 32'(pending);
                IDX_ENABLE:  rdata = 32'(enable);
                IDX_MODE:    rdata = 32'(mode);
                default:     ;
            endcase
            for (int k = 0; k < NUM_IRQ; k++)
                if (idx == 6'(IDX_ROUTE + k)) rdata = 32'(route[k]);
            for (int i = 0; i < NUM_EVT; i++)
                if (idx == 6'(IDX_COUNT + i)) rdata = 32'(count[i]);
        end
    end

    // Wishbone ack pulse and read data, both valid only in the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
        end
    end

    // Edge history, sticky pending bits (set beats W1C) and RW control registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            // evt_prev tracks the inputs during reset so held levels give no edge at release.
            evt_prev <= evt_i;
            pending  <= '0;
            enable   <= '0;
            mode     <= '0;
            // NOTE: ROUTE and COUNT are small flop arrays, not RAM, so they are reset like any register.
            for (int k = 0; k < NUM_IRQ; k++) route[k] <= '0;
        end else begin
            evt_prev <= evt_i;
            pending  <= (pending & ~((wr_en && idx == IDX_PENDING) ? (wdata & wmask) : '0))
                        | evt_edge;
            if (wr_en && idx == IDX_ENABLE) enable <= (enable & ~wmask) | (wdata & wmask);
            if (wr_en && idx == IDX_MODE)   mode   <= (mode & ~wmask) | (wdata & wmask);
            for (int k = 0; k < NUM_IRQ; k++)
                if (route_wr[k]) route[k] <= (route[k] & ~wmask) | (wdata & wmask);
        end
    end

    // Saturating edge counters; a clear coinciding with an edge leaves 1.
    always_ff @(posedge wb_clk_i) begin
        for (int i = 0; i < NUM_EVT; i++) begin
            if (wb_rst_i)
                count[i] <= '0;
            else if (cnt_clr[i])
                count[i] <= CNT_W'(evt_edge[i]);
            else if (evt_edge[i] && count[i] != CNT_MAX)
                count[i] <= count[i] + CNT_W'(1);
        end
    end

    // Registered irq lines and the global pending flag, one cycle behind PENDING.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq           <= '0;
            evt_pending_o <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_IRQ; k++)
                irq[k] <= |(pending & enable & route[k]);
            evt_pending_o <= |pending;
        end
    end

endmodule

// File: tb/tb_wbs_event_irq_ctrl.sv
// Directed bench for wbs_event_irq_ctrl: read expectations are queued when a
// read is issued and compared when the DUT acks it.
module tb_wbs_event_irq_ctrl;

    localparam logic [31:0] BA = 32'h3000_0100;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_dat_i = '0;
    logic [31:0] wbs_adr_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [7:0]  evt_i = '0;
    logic [2:0]  irq;
    logic        evt_pending_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    wbs_event_irq_ctrl #(
        .NUM_EVT  (8),
        .NUM_IRQ  (3),
        .CNT_W    (4),
        .BASE_ADDR(BA)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_cyc_i    (wbs_cyc_i),
        .wbs_we_i     (wbs_we_i),
        .wbs_sel_i    (wbs_sel_i),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_adr_i    (wbs_adr_i),
        .wbs_ack_o    (wbs_ack_o),
        .wbs_dat_o    (wbs_dat_o),
        .evt_i        (evt_i),
        .irq          (irq),
        .evt_pending_o(evt_pending_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200_000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus transfer; evt_val is applied in the same cycle the request is presented.
    task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [7:0] evt_val,
                            output logic [31:0] rdat);
        int waited;
        waited = 0;
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        evt_i     = evt_val;
        do begin
            @(negedge wb_clk_i);
            waited++;
        end while (!wbs_ack_o && waited < 8);
        check("ack_latency", 32'(waited), 32'd1);
        rdat      = wbs_dat_o;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write_ev(input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [7:0] evt_val);
        logic [31:0] rd;
        bus_xfer(1'b1, adr, dat, sel, evt_val, rd);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        wb_write_ev(adr, dat, 4'hF, evt_i);
    endtask

    task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_xfer(1'b0, adr, 32'h0, 4'hF, evt_i, rd);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            check(tag_q.pop_front(), rd, exp_q.pop_front());
        end
    endtask

    task automatic do_reset(input logic [7:0] evt_val);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        evt_i    = evt_val;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
    endtask

    initial begin
        // Reset state and basic read handshake
        do_reset(8'h00);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_evt_pending", 32'(evt_pending_o), 32'd0);
        wb_read(BA + 32'h04, 32'h0, "rst_pending");
        wb_read(BA + 32'h08, 32'h0, "rst_enable");
        wb_read(BA + 32'h40, 32'h0, "rst_count0");
        @(negedge wb_clk_i);
        check("ack_one_cycle", 32'(wbs_ack_o), 32'd0);
        check("dat_idle_zero", wbs_dat_o, 32'd0);
        check("rst_irq_after", 32'(irq), 32'd0);

        // Rising edge on evt 0 routed to irq[0], then W1C
        wb_write(BA + 32'h08, 32'h01);
        wb_write(BA + 32'h20, 32'h01);
        evt_i = 8'h01;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("irq_after_t", 32'(irq), 32'd0);
        check("evtp_after_t", 32'(evt_pending_o), 32'd0);
        @(negedge wb_clk_i);
        check("irq_after_t1", 32'(irq), 32'b001);
        check("evtp_after_t1", 32'(evt_pending_o), 32'd1);
        wb_read(BA + 32'h04, 32'h01, "pending_evt0");
        wb_read(BA + 32'h00, 32'h01, "status_live");
        wb_write(BA + 32'h04, 32'h01);
        check("irq_at_w1c_ack", 32'(irq), 32'b001);
        @(negedge wb_clk_i);
        check("irq_after_w1c", 32'(irq), 32'd0);
        check("evtp_after_w1c", 32'(evt_pending_o), 32'd0);
        evt_i = 8'h00;

        // Falling-edge mode on evt 3
        wb_write(BA + 32'h0C, 32'h08);
        evt_i = 8'h08;
        repeat (2) @(negedge wb_clk_i);
        wb_read(BA + 32'h04, 32'h00, "fall_no_capture_on_rise");
        evt_i = 8'h00;
        repeat (2) @(negedge wb_clk_i);
        wb_read(BA + 32'h04, 32'h08, "fall_capture");
        wb_read(BA + 32'h4C, 32'h01, "count3");
        check("irq_masked_evt3", 32'(irq), 32'd0);
        wb_write(BA + 32'h04, 32'h08);
        wb_read(BA + 32'h04, 32'h00, "pending_cleared3");

        // MODE write with a coincident rising edge: old (rising) mode applies
        wb_write_ev(BA + 32'h0C, 32'h18, 4'hF, 8'h10);
        wb_read(BA + 32'h04, 32'h10, "mode_old_applies");
        wb_read(BA + 32'h0C, 32'h18, "mode_readback");
        wb_write(BA + 32'h04, 32'h10);
        wb_read(BA + 32'h04, 32'h00, "pending_cleared4");
        evt_i = 8'h00;
        repeat (2) @(negedge wb_clk_i);
        wb_read(BA + 32'h04, 32'h10, "mode_new_applies");
        wb_write(BA + 32'h04, 32'h10);
        wb_read(BA + 32'h50, 32'h02, "count4");

        // Byte select gating: byte 0 disabled, ENABLE must not change
        wb_write_ev(BA + 32'h08, 32'hFF, 4'b1110, evt_i);
        wb_read(BA + 32'h08, 32'h01, "sel_gating");

        // Set beats W1C, enable masking, multi-line routing
        evt_i = 8'h02;
        @(negedge wb_clk_i);
        evt_i = 8'h00;
        @(negedge wb_clk_i);
        check("evtp_evt1", 32'(evt_pending_o), 32'd1);
        check("irq_disabled_evt1", 32'(irq), 32'd0);
        wb_write_ev(BA + 32'h04, 32'h02, 4'hF, 8'h02);
        wb_read(BA + 32'h04, 32'h02, "set_beats_w1c");
        evt_i = 8'h00;
        wb_write(BA + 32'h24, 32'h02);
        wb_write(BA + 32'h28, 32'h02);
        wb_write(BA + 32'h08, 32'h03);
        repeat (2) @(negedge wb_clk_i);
        check("irq_multi_route", 32'(irq), 32'b110);
        wb_read(BA + 32'h2C, 32'h00, "route_beyond_num_irq");
        wb_write(BA + 32'h04, 32'h02);
        repeat (2) @(negedge wb_clk_i);
        check("irq_multi_cleared", 32'(irq), 32'd0);
        wb_read(BA + 32'h04, 32'h00, "pending_cleared1");

        // Foreign base address and unmapped offsets
        wb_read(32'h0000_0108, 32'h0, "foreign_low_enable");
        wb_read(32'h3000_0008, 32'h0, "foreign_base_enable");
        wb_read(BA + 32'h10, 32'h0, "unmapped_offset");
        wb_write(32'h3000_0008, 32'h00);
        wb_read(BA + 32'h08, 32'h03, "foreign_write_ignored");

        // Counter saturation at 2^4-1 and clear behaviour
        for (int n = 0; n < 20; n++) begin
            @(negedge wb_clk_i);
            evt_i = 8'h04;
            @(negedge wb_clk_i);
            evt_i = 8'h00;
        end
        wb_read(BA + 32'h48, 32'h0F, "count2_saturated");
        wb_write(BA + 32'h48, 32'h1234);
        wb_read(BA + 32'h48, 32'h00, "count2_cleared");
        wb_write_ev(BA + 32'h48, 32'h0, 4'hF, 8'h04);
        wb_read(BA + 32'h48, 32'h01, "count2_clear_with_edge");
        evt_i = 8'h00;

        // Reset during an outstanding request, with evt 0 held high through release
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = BA + 32'h08;
        wb_rst_i  = 1'b1;
        evt_i     = 8'h01;
        @(negedge wb_clk_i);
        check("no_ack_in_reset", 32'(wbs_ack_o), 32'd0);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        wb_read(BA + 32'h04, 32'h00, "held_level_no_pending");
        wb_read(BA + 32'h40, 32'h00, "held_level_no_count");
        wb_read(BA + 32'h08, 32'h00, "enable_after_reset");
        check("irq_after_reset", 32'(irq), 32'd0);
        check("evtp_after_reset", 32'(evt_pending_o), 32'd0);
        evt_i = 8'h00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wbs_event_irq_ctrl.md
Name: wbs_event_irq_ctrl

Overview:
Parametrised event/interrupt controller on the user-project Wishbone slave bus. It replaces the hard-wired irq = 0 and the ad-hoc synced status bits with one general mechanism. Each of NUM_EVT event inputs (fsm_done, load_done, send_done, etc., already synchronised to wb_clk_i) gets:
- per-event edge capture into sticky pending bits
- per-event saturating counters
- enable masking
- routing to any of NUM_IRQ interrupt lines

Parameters:
NUM_EVT, 8, number of event inputs (1..32)
NUM_IRQ, 3, number of irq outputs (1..8)
CNT_W, 16, event counter width (1..32)
BASE_ADDR, 32'h3000_0100, register block base; decode on adr[31:8], offset adr[7:0]

Ports:
wb_clk_i  input  1  clock; all logic on rising edge
wb_rst_i  input  1  synchronous active-high reset
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte selects
wbs_dat_i  input  32  write data
wbs_adr_i  input  32  byte address
wbs_ack_o  output  1  acknowledge
wbs_dat_o  output  32  read data
evt_i  input  NUM_EVT  event levels, synchronous to wb_clk_i
irq  output  NUM_IRQ  interrupt lines, registered, active-high
evt_pending_o  output  1  OR of all pending bits, registered (GPIO status)

Behaviour:
Clock and reset: one clock, wb_clk_i. Reset is synchronous, active-high, on wb_rst_i.

Reset state:
- wbs_ack_o=0, wbs_dat_o=0, irq=0, evt_pending_o=0
- PENDING=0, ENABLE=0, MODE=0, all ROUTE=0, all COUNT=0
- evt_prev loads evt_i every reset cycle, so levels present at reset release produce no edge.

Register map (word offsets; bits above NUM_EVT read 0 and ignore writes):
- 0x00 STATUS (RO): live evt_i.
- 0x04 PENDING (W1C): sticky edge captures.
- 0x08 ENABLE (RW): per-event IRQ enable.
- 0x0C MODE (RW): per event, 0 = rising-edge capture, 1 = falling-edge capture.
- 0x20+4k ROUTE[k] (RW), k<NUM_IRQ: event mask for irq[k].
- 0x40+4i COUNT[i] (RW-clear), i<NUM_EVT: edge count. Any write clears it; written data is ignored.
- Any other offset, or adr[31:8] != BASE_ADDR[31:8]: read returns 0, write is ignored, ack is still given.

Wishbone handshake:
- A request is stb&cyc&!ack.
- wbs_ack_o pulses high for exactly 1 cycle, the cycle after the request is sampled.
- wbs_dat_o is valid in that ack cycle and is 0 otherwise.
- Back-to-back requests therefore complete at most every 2 cycles.
- A write takes effect at the same edge that raises ack.
- wbs_sel_i[b] gates byte b for RW and W1C registers. For COUNT, any nonzero sel clears.

Event path, for event i:
- edge_i = MODE[i] ? (evt_prev[i] & !evt_i[i]) : (!evt_prev[i] & evt_i[i])
- evt_prev <= evt_i every cycle.
- When edge_i is detected at edge t, PENDING[i]=1 is visible after edge t.
- Pending capture and counting are independent of ENABLE.
- COUNT[i] increments on edge_i and saturates at 2^CNT_W-1 (no wrap).

IRQ path:
- irq[k] <= |(PENDING & ENABLE & ROUTE[k]), registered. It rises 1 cycle after PENDING is set, giving 2 cycles total edge-to-irq.
- evt_pending_o <= |PENDING, same timing.

Simultaneous events:
- W1C clear and a new edge on the same bit in the same cycle: set wins, PENDING stays 1.
- COUNT clear and an edge in the same cycle: COUNT = 1.
- MODE write and an event transition in the same cycle: the old MODE applies for that cycle.
- An event routed to several ROUTE[k] asserts all of those irq lines.

Reset mid-transaction: an outstanding request gets no ack, and all state returns to reset values at that edge. The bus master must retry.

Test Plan:
1. Reset, then read 0x04, 0x08 and 0x40 → all 0. Ack comes exactly 1 cycle after stb&cyc; irq=0.
2. Write ENABLE=0x01 and ROUTE[0]=0x01, then pulse evt_i[0] 0→1 at edge t → PENDING[0]=1 after t, irq[0]=1 after t+1, irq[1]=irq[2]=0. Write 0x04 ← 0x01 → irq[0]=0 one cycle after ack.
3. Set MODE[3]=1 and drive evt_i[3] low→high→low → PENDING reads 0x08 only after the fall; COUNT[3]=1.
4. Hold evt_i[0]=1 through reset release → PENDING=0 and COUNT[0]=0.
5. With CNT_W=4, give 20 rising edges on evt_i[2] → COUNT[2]=15. Write 0x48 → reads 0. An edge coinciding with the clear → reads 1.
6. Edge on evt_i[1] in the same cycle as W1C of bit 1 → PENDING[1]=1. Read at 0x100 or 0x04 with BASE_ADDR mismatch → returns 0, ack given.
